// File: rtl/fp8_vec_mul_pipe.sv
// FP8 (E4M3/E5M2) scalar x vector multiplier producing exact BF16 products, STAGES-deep ready/valid pipeline.
// Optional NaN-lane counter (cnt_clr / nan_cnt) is built only when FP8_PIPE_NAN_CNT_EN is defined.
module fp8_vec_mul_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 3,
    parameter int TAG_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 e5m2mode,
    input  logic [7:0]           q,
    input  logic [8*LANES-1:0]   vec,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [16*LANES-1:0]  prod,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef FP8_PIPE_NAN_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [15:0]          nan_cnt
`endif
);

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    typedef struct packed {
        logic              sgn;
        cls_e              cls;
        logic signed [5:0] exp;
        logic [3:0]        sig;
    } opnd_t;

    typedef struct packed {
        logic              sgn;
        cls_e              cls;
        logic signed [5:0] ea;
        logic signed [5:0] eb;
        logic [3:0]        ma;
        logic [3:0]        mb;
    } dec_t;

    typedef struct packed {
        logic              sgn;
        cls_e              cls;
        logic signed [6:0] exp;
        logic [7:0]        sig;
    } mul_t;

    // Significands are held as 1.fff; E5M2 simply carries a trailing zero fraction bit.
    function automatic opnd_t decode(input logic [7:0] b, input logic e5);
        opnd_t o;
        o     = '0;
        o.sgn = b[7];
        o.cls = CLS_NUM;
        if (!e5) begin
            if (b[6:0] == 7'h7F)        o.cls = CLS_NAN;
            else if (b[6:0] == 7'h00)   o.cls = CLS_ZERO;
            else if (b[6:3] != 4'h0) begin
                o.exp = $signed({2'b00, b[6:3]}) - 6'sd7;
                o.sig = {1'b1, b[2:0]};
            end
            else if (b[2]) begin o.exp = -6'sd7; o.sig = {b[2:0], 1'b0}; end
            else if (b[1]) begin o.exp = -6'sd8; o.sig = {b[1:0], 2'b00}; end
            else           begin o.exp = -6'sd9; o.sig = 4'b1000;         end
        end else begin
            if (b[6:2] == 5'h1F)        o.cls = (b[1:0] != 2'b00) ? CLS_NAN : CLS_INF;
            else if (b[6:0] == 7'h00)   o.cls = CLS_ZERO;
            else if (b[6:2] != 5'h00) begin
                o.exp = $signed({1'b0, b[6:2]}) - 6'sd15;
                o.sig = {1'b1, b[1:0], 1'b0};
            end
            else if (b[1]) begin o.exp = -6'sd15; o.sig = {b[1:0], 2'b00}; end
            else           begin o.exp = -6'sd16; o.sig = 4'b1000;         end
        end
        return o;
    endfunction

    function automatic dec_t combine(input opnd_t a, input opnd_t b);
        dec_t d;
        d.sgn = a.sgn ^ b.sgn;
        d.ea  = a.exp;
        d.eb  = b.exp;
        d.ma  = a.sig;
        d.mb  = b.sig;
        if (a.cls == CLS_NAN || b.cls == CLS_NAN ||
            (a.cls == CLS_INF && b.cls == CLS_ZERO) || (a.cls == CLS_ZERO && b.cls == CLS_INF))
            d.cls = CLS_NAN;
        else if (a.cls == CLS_INF || b.cls == CLS_INF)
            d.cls = CLS_INF;
        else if (a.cls == CLS_ZERO || b.cls == CLS_ZERO)
            d.cls = CLS_ZERO;
        else
            d.cls = CLS_NUM;
        return d;
    endfunction

    function automatic mul_t mul(input dec_t d);
        mul_t m;
        m.sgn = d.sgn;
        m.cls = d.cls;
        m.exp = {d.ea[5], d.ea} + {d.eb[5], d.eb};
        m.sig = {4'b0000, d.ma} * {4'b0000, d.mb};
        return m;
    endfunction

    // Product sits in [1,4) with six fraction bits, so the BF16 result is always exact.
    function automatic logic [15:0] pack(input mul_t m);
        logic signed [6:0] e;
        logic [6:0]        f;
        logic [7:0]        be;
        logic [15:0]       r;
        e = m.exp;
        f = {m.sig[5:0], 1'b0};
        if (m.sig[7]) begin
            e = m.exp + 7'sd1;
            f = m.sig[6:0];
        end
        be = {e[6], e} + 8'd127;
        case (m.cls)
            CLS_NAN:  r = 16'h7FC0;
            CLS_INF:  r = {m.sgn, 15'h7F80};
            CLS_ZERO: r = {m.sgn, 15'h0000};
            default:  r = {m.sgn, be, f};
        endcase
        return r;
    endfunction

    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    dec_t w_dec [LANES];
    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_dec[i] = combine(decode(q, e5m2mode), decode(vec[8*i +: 8], e5m2mode));
    end

    logic             r_v1;
    logic [TAG_W-1:0] r_t1;
    dec_t             r_s1 [LANES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_t1 <= '0;
            for (int i = 0; i < LANES; i++) r_s1[i] <= '0;
        end else if (!w_stall) begin
            r_v1 <= in_valid;
            r_t1 <= in_tag;
            for (int i = 0; i < LANES; i++) r_s1[i] <= w_dec[i];
        end
    end

    logic [16*LANES-1:0] w_packed;
    logic                w_v_pk;
    logic [TAG_W-1:0]    w_t_pk;

    if (STAGES == 2) begin : g_merged
        always_comb begin
            w_packed = '0;
            for (int i = 0; i < LANES; i++) w_packed[16*i +: 16] = pack(mul(r_s1[i]));
        end
        assign w_v_pk = r_v1;
        assign w_t_pk = r_t1;
    end else begin : g_split
        logic             r_v2;
        logic [TAG_W-1:0] r_t2;
        mul_t             r_s2 [LANES];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v2 <= 1'b0;
                r_t2 <= '0;
                for (int i = 0; i < LANES; i++) r_s2[i] <= '0;
            end else if (!w_stall) begin
                r_v2 <= r_v1;
                r_t2 <= r_t1;
                for (int i = 0; i < LANES; i++) r_s2[i] <= mul(r_s1[i]);
            end
        end

        always_comb begin
            w_packed = '0;
            for (int i = 0; i < LANES; i++) w_packed[16*i +: 16] = pack(r_s2[i]);
        end
        assign w_v_pk = r_v2;
        assign w_t_pk = r_t2;
    end

    logic                r_v3;
    logic [TAG_W-1:0]    r_t3;
    logic [16*LANES-1:0] r_p3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v3 <= 1'b0;
            r_t3 <= '0;
            r_p3 <= '0;
        end else if (!w_stall) begin
            r_v3 <= w_v_pk;
            r_t3 <= w_t_pk;
            r_p3 <= w_packed;
        end
    end

    if (STAGES == 4) begin : g_extra
        logic                r_v4;
        logic [TAG_W-1:0]    r_t4;
        logic [16*LANES-1:0] r_p4;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v4 <= 1'b0;
                r_t4 <= '0;
                r_p4 <= '0;
            end else if (!w_stall) begin
                r_v4 <= r_v3;
                r_t4 <= r_t3;
                r_p4 <= r_p3;
            end
        end
        assign out_valid = r_v4;
        assign out_tag   = r_t4;
        assign prod      = r_p4;
    end else begin : g_direct
        assign out_valid = r_v3;
        assign out_tag   = r_t3;
        assign prod      = r_p3;
    end

`ifdef FP8_PIPE_NAN_CNT_EN
    logic [4:0]  w_nan_lanes;
    logic [16:0] w_sum;
    logic        w_out_hs;
    logic [15:0] r_nan_cnt;

    always_comb begin
        w_nan_lanes = '0;
        for (int i = 0; i < LANES; i++)
            if (prod[16*i +: 16] == 16'h7FC0) w_nan_lanes = w_nan_lanes + 5'd1;
    end
    assign w_sum    = {1'b0, r_nan_cnt} + {12'b0, w_nan_lanes};
    assign w_out_hs = out_valid && out_ready;

    // A clear that coincides with a handshake restarts the count from that beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_nan_cnt <= '0;
        else if (cnt_clr)
            r_nan_cnt <= w_out_hs ? {11'b0, w_nan_lanes} : 16'h0000;
        else if (w_out_hs)
            r_nan_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
    assign nan_cnt = r_nan_cnt;
`endif

endmodule
